pipelined_core: RTL and testbench

//  Parametrised 4-stage (Fetch/Decode/Execute/Write-back) core. Owns its instruction RAM, register file and ALU.

---
 rtl/pipelined_core.sv | 151 +++++++++++++++
 tb/tb_pipelined_core.sv | 341 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/pipelined_core.sv
// Four-stage F/D/E/W core with private instruction RAM, register file and ALU.
// Full E>W>regfile forwarding into decode, sticky HALT/illegal flags, and pause/resume.
module pipelined_core #(
   parameter  int unsigned DW         = 32,
   parameter  int unsigned NREGS      = 8,
   parameter  int unsigned IMEM_DEPTH = 512,
   localparam int unsigned AW         = $clog2(IMEM_DEPTH)
) (
   input  logic          clock,
   input  logic          reset,
   input  logic          working,
   input  logic          wr,
   input  logic [AW-1:0] addr,
   input  logic [31:0]   wdata,
   input  logic [3:0]    dbg_sel,
   output logic [DW-1:0] dbg_data,
   output logic [DW-1:0] valE,
   output logic [AW-1:0] pc,
   output logic          halted,
   output logic          err
);

   localparam int unsigned RW       = (NREGS > 1) ? $clog2(NREGS) : 1;
   localparam logic [31:0] NOP_WORD = 32'h0100_0000;

   typedef enum logic [2:0] {
      OP_NOP, OP_HALT, OP_IRMOV, OP_ADD, OP_SUB, OP_AND, OP_XOR
   } op_t;

   function automatic logic implemented(input logic [3:0] idx);
      return 5'(idx) < 5'(NREGS);
   endfunction

   logic [31:0]   mem [IMEM_DEPTH];
   logic [DW-1:0] rf  [NREGS];

   logic [31:0]   ir;
   logic          fetch_stop;
   logic          run;
   logic [AW-1:0] pc_next;

   op_t           e_op;
   logic [DW-1:0] e_a, e_b, e_valc;
   logic [3:0]    e_dst;
   logic          e_we;

   logic [3:0]    w_dst;
   logic          w_we;

   op_t           d_op;
   logic [3:0]    d_ra, d_rb, d_dst;
   logic          d_we, d_illegal;
   logic [DW-1:0] rf_a, rf_b, op_a, op_b, alu_res;

   assign run     = working & ~halted;
   assign pc_next = (pc == AW'(IMEM_DEPTH - 1)) ? '0 : pc + AW'(1);
   assign d_ra    = ir[23:20];
   assign d_rb    = ir[19:16];

   assign rf_a     = implemented(d_ra)    ? rf[RW'(d_ra)]    : '0;
   assign rf_b     = implemented(d_rb)    ? rf[RW'(d_rb)]    : '0;
   assign dbg_data = implemented(dbg_sel) ? rf[RW'(dbg_sel)] : '0;

   // Decode; writes to unimplemented registers are dropped here so they never forward
   always_comb begin
      d_op      = OP_NOP;
      d_dst     = d_rb;
      d_we      = 1'b0;
      d_illegal = 1'b0;
      case (ir[31:24])
         8'h00:   d_op = OP_HALT;
         8'h01:   d_op = OP_NOP;
         8'h10:   begin d_op = OP_IRMOV; d_dst = d_rb; d_we = 1'b1; end
         8'h20:   begin d_op = OP_ADD;   d_dst = d_ra; d_we = 1'b1; end
         8'h21:   begin d_op = OP_SUB;   d_dst = d_ra; d_we = 1'b1; end
         8'h22:   begin d_op = OP_AND;   d_dst = d_ra; d_we = 1'b1; end
         8'h23:   begin d_op = OP_XOR;   d_dst = d_ra; d_we = 1'b1; end
         default: d_illegal = 1'b1;
      endcase
      if (!implemented(d_dst)) d_we = 1'b0;
   end

   // Operand bypass, later assignment wins: E over W over register file
   always_comb begin
      op_a = rf_a;
      op_b = rf_b;
      if (w_we && w_dst == d_ra) op_a = valE;
      if (w_we && w_dst == d_rb) op_b = valE;
      if (e_we && e_dst == d_ra) op_a = alu_res;
      if (e_we && e_dst == d_rb) op_b = alu_res;
   end

   always_comb begin
      alu_res = '0;
      case (e_op)
         OP_IRMOV: alu_res = e_valc;
         OP_ADD:   alu_res = e_a + e_b;
         OP_SUB:   alu_res = e_a - e_b;
         OP_AND:   alu_res = e_a & e_b;
         OP_XOR:   alu_res = e_a ^ e_b;
         default:  alu_res = '0;
      endcase
   end

   // Load port; only open while the pipeline is frozen
   always_ff @(posedge clock) begin
      if (!reset && !working && wr) mem[addr] <= wdata;
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         pc         <= '0;
         ir         <= NOP_WORD;
         fetch_stop <= 1'b0;
         e_op       <= OP_NOP;
         e_a        <= '0;
         e_b        <= '0;
         e_valc     <= '0;
         e_dst      <= '0;
         e_we       <= 1'b0;
         valE       <= '0;
         w_dst      <= '0;
         w_we       <= 1'b0;
         halted     <= 1'b0;
         err        <= 1'b0;
         for (int i = 0; i < NREGS; i++) rf[i] <= '0;
      end else if (run) begin
         // A decoded HALT parks the PC just past itself and starves IR with NOPs
         if (fetch_stop || d_op == OP_HALT) begin
            ir <= NOP_WORD;
         end else begin
            ir <= mem[pc];
            pc <= pc_next;
         end
         fetch_stop <= fetch_stop | (d_op == OP_HALT);
         e_op       <= d_op;
         e_a        <= op_a;
         e_b        <= op_b;
         e_valc     <= DW'(ir[15:0]);
         e_dst      <= d_dst;
         e_we       <= d_we;
         err        <= err | d_illegal;
         valE       <= alu_res;
         w_dst      <= e_dst;
         w_we       <= e_we;
         if (e_op == OP_HALT) halted <= 1'b1;
         if (w_we) rf[RW'(w_dst)] <= valE;
      end
   end

endmodule

// File: tb/tb_pipelined_core.sv
// Self-checking bench for pipelined_core: directed scenarios plus random programs
// compared against a sequential instruction-level model.
module tb_pipelined_core;

   logic        clock;
   logic        reset, working, wr;
   logic [8:0]  addr;
   logic [31:0] wdata;
   logic [3:0]  dbg_sel;
   logic [31:0] dbg_data, val_e;
   logic [8:0]  pc;
   logic        halted, err;

   logic        s_reset, s_working, s_wr;
   logic [3:0]  s_addr;
   logic [31:0] s_wdata;
   logic [3:0]  s_dbg_sel;
   logic [31:0] s_dbg_data, s_val_e;
   logic [3:0]  s_pc;
   logic        s_halted, s_err;

   int checks = 0;
   int errors = 0;

   pipelined_core dut (
      .clock(clock), .reset(reset), .working(working), .wr(wr), .addr(addr),
      .wdata(wdata), .dbg_sel(dbg_sel), .dbg_data(dbg_data), .valE(val_e),
      .pc(pc), .halted(halted), .err(err)
   );

   pipelined_core #(.IMEM_DEPTH(16)) dut_small (
      .clock(clock), .reset(s_reset), .working(s_working), .wr(s_wr), .addr(s_addr),
      .wdata(s_wdata), .dbg_sel(s_dbg_sel), .dbg_data(s_dbg_data), .valE(s_val_e),
      .pc(s_pc), .halted(s_halted), .err(s_err)
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   localparam logic [31:0] HALT_W = 32'h0000_0000;
   localparam logic [31:0] NOP_W  = 32'h0100_0000;

   function automatic logic [31:0] irmov(input logic [3:0] rb, input logic [15:0] v);
      return {8'h10, 4'hF, rb, v};
   endfunction

   function automatic logic [31:0] alu(input logic [3:0] f, input logic [3:0] ra, input logic [3:0] rb);
      return {4'h2, f, ra, rb, 16'h0000};
   endfunction

   // Sequential reference: executes one instruction at a time, no pipeline notion
   logic [31:0] m_reg [16];
   bit          m_err;
   int          m_pc;

   task automatic model_run(input logic [31:0] prog [$]);
      logic [31:0] ins, a, b;
      int p;
      bit done;
      for (int i = 0; i < 16; i++) m_reg[i] = '0;
      m_err = 0;
      p     = 0;
      done  = 0;
      for (int s = 0; s < 4096 && !done; s++) begin
         ins = (p < prog.size()) ? prog[p] : HALT_W;
         p++;
         a = (ins[23:20] < 8) ? m_reg[ins[23:20]] : 32'h0;
         b = (ins[19:16] < 8) ? m_reg[ins[19:16]] : 32'h0;
         case (ins[31:24])
            8'h00: done = 1;
            8'h01: ;
            8'h10: if (ins[19:16] < 8) m_reg[ins[19:16]] = {16'h0, ins[15:0]};
            8'h20: if (ins[23:20] < 8) m_reg[ins[23:20]] = a + b;
            8'h21: if (ins[23:20] < 8) m_reg[ins[23:20]] = a - b;
            8'h22: if (ins[23:20] < 8) m_reg[ins[23:20]] = a & b;
            8'h23: if (ins[23:20] < 8) m_reg[ins[23:20]] = a ^ b;
            default: m_err = 1;
         endcase
      end
      m_pc = p;
   endtask

   logic [31:0] prog1 [$];
   logic [31:0] exp1  [16];

   task automatic tick();
      @(posedge clock);
      #1;
   endtask

   task automatic do_reset();
      reset = 1'b1;
      tick();
      reset = 1'b0;
   endtask

   task automatic load_prog(input logic [31:0] prog [$]);
      working = 1'b0;
      foreach (prog[i]) begin
         addr  = 9'(i);
         wdata = prog[i];
         wr    = 1'b1;
         tick();
      end
      wr = 1'b0;
   endtask

   task automatic run_prog(input bit rand_pause);
      for (int c = 0; c < 3000 && !halted; c++) begin
         working = rand_pause ? ($urandom_range(3) != 0) : 1'b1;
         tick();
      end
      working = 1'b0;
      checks++;
      if (halted !== 1'b1) begin
         errors++;
         $display("FAIL run_timeout halted=%b required 1", halted);
      end
   endtask

   task automatic test_reset();
      do_reset();
      checks += 4;
      if (pc !== 9'd0)     begin errors++; $display("FAIL reset_pc got %0d exp 0", pc); end
      if (halted !== 1'b0) begin errors++; $display("FAIL reset_halted got %b exp 0", halted); end
      if (err !== 1'b0)    begin errors++; $display("FAIL reset_err got %b exp 0", err); end
      if (val_e !== 32'h0) begin errors++; $display("FAIL reset_valE got %h exp 0", val_e); end
      for (int i = 0; i < 16; i++) begin
         dbg_sel = 4'(i); #1;
         checks++;
         if (dbg_data !== 32'h0) begin errors++; $display("FAIL reset_r%0d got %h exp 0", i, dbg_data); end
      end
   endtask

   task automatic test_alu_ops();
      load_prog(prog1);
      do_reset();
      run_prog(0);
      checks += 2;
      if (pc !== 9'd13) begin errors++; $display("FAIL alu_pc got %0d exp 13", pc); end
      if (err !== 1'b0) begin errors++; $display("FAIL alu_err got %b exp 0", err); end
      for (int i = 0; i < 16; i++) begin
         dbg_sel = 4'(i); #1;
         checks++;
         if (dbg_data !== exp1[i]) begin errors++; $display("FAIL alu_r%0d got %h exp %h", i, dbg_data, exp1[i]); end
      end
   endtask

   task automatic test_forwarding();
      logic [31:0] prog [$];
      logic [31:0] exp_v [3];
      prog = '{irmov(4'd0, 16'd5), alu(4'h0, 4'd0, 4'd0), alu(4'h0, 4'd0, 4'd0), HALT_W};
      exp_v = '{32'h5, 32'hA, 32'h14};
      load_prog(prog);
      do_reset();
      dbg_sel = 4'd0;
      working = 1'b1;
      for (int k = 1; k <= 5; k++) begin
         tick();
         if (k >= 3) begin
            checks++;
            if (val_e !== exp_v[k-3]) begin errors++; $display("FAIL fwd_valE_cycle%0d got %h exp %h", k, val_e, exp_v[k-3]); end
         end
         if (k == 3) begin
            checks++;
            if (dbg_data !== 32'h0) begin errors++; $display("FAIL fwd_r0_before_wb got %h exp 0", dbg_data); end
         end
         if (k == 4) begin
            checks++;
            if (dbg_data !== 32'h5) begin errors++; $display("FAIL fwd_r0_latency got %h exp 5", dbg_data); end
         end
      end
      run_prog(0);
      #1;
      checks++;
      if (dbg_data !== 32'h14) begin errors++; $display("FAIL fwd_r0_final got %h exp 14", dbg_data); end
   endtask

   task automatic test_pause();
      logic [8:0] held;
      load_prog(prog1);
      do_reset();
      working = 1'b1;
      repeat (6) tick();
      working = 1'b0;
      held = pc;
      checks++;
      if (held !== 9'd6) begin errors++; $display("FAIL pause_pc_start got %0d exp 6", held); end
      // Overwrite the word sitting in IR and an older one; neither may take effect
      for (int k = 0; k < 7; k++) begin
         addr  = (k % 2 == 0) ? 9'd5 : 9'd2;
         wdata = irmov(4'(k % 8), 16'($urandom));
         wr    = 1'b1;
         tick();
         checks++;
         if (pc !== held) begin errors++; $display("FAIL pause_pc_frozen got %0d exp %0d", pc, held); end
      end
      wr = 1'b0;
      run_prog(0);
      for (int i = 0; i < 16; i++) begin
         dbg_sel = 4'(i); #1;
         checks++;
         if (dbg_data !== exp1[i]) begin errors++; $display("FAIL pause_r%0d got %h exp %h", i, dbg_data, exp1[i]); end
      end
   endtask

   task automatic test_illegal();
      logic [31:0] prog [$];
      logic [31:0] exp_r [16];
      prog = '{irmov(4'd1, 16'h0011), 32'h3700_0000, irmov(4'd2, 16'h0022), HALT_W};
      for (int i = 0; i < 16; i++) exp_r[i] = '0;
      exp_r[1] = 32'h11;
      exp_r[2] = 32'h22;
      load_prog(prog);
      do_reset();
      run_prog(0);
      checks++;
      if (err !== 1'b1) begin errors++; $display("FAIL illegal_err got %b exp 1", err); end
      for (int i = 0; i < 16; i++) begin
         dbg_sel = 4'(i); #1;
         checks++;
         if (dbg_data !== exp_r[i]) begin errors++; $display("FAIL illegal_r%0d got %h exp %h", i, dbg_data, exp_r[i]); end
      end
   endtask

   task automatic test_reset_midrun();
      load_prog(prog1);
      do_reset();
      working = 1'b1;
      repeat (10) tick();
      reset = 1'b1;
      tick();
      reset   = 1'b0;
      working = 1'b0;
      checks += 3;
      if (pc !== 9'd0)     begin errors++; $display("FAIL midreset_pc got %0d exp 0", pc); end
      if (halted !== 1'b0) begin errors++; $display("FAIL midreset_halted got %b exp 0", halted); end
      if (err !== 1'b0)    begin errors++; $display("FAIL midreset_err got %b exp 0", err); end
      for (int i = 0; i < 8; i++) begin
         dbg_sel = 4'(i); #1;
         checks++;
         if (dbg_data !== 32'h0) begin errors++; $display("FAIL midreset_r%0d got %h exp 0", i, dbg_data); end
      end
      run_prog(0);
      for (int i = 0; i < 16; i++) begin
         dbg_sel = 4'(i); #1;
         checks++;
         if (dbg_data !== exp1[i]) begin errors++; $display("FAIL rerun_r%0d got %h exp %h", i, dbg_data, exp1[i]); end
      end
   endtask

   task automatic test_random_programs();
      logic [31:0] prog [$];
      logic [7:0]  bad_codes [5];
      int n, sel;
      bad_codes = '{8'h37, 8'h24, 8'h11, 8'h02, 8'hF0};
      for (int t = 0; t < 20; t++) begin
         prog.delete();
         n = $urandom_range(30, 4);
         for (int i = 0; i < n; i++) begin
            sel = $urandom_range(9);
            if (sel <= 2)      prog.push_back(irmov(4'($urandom_range(9)), 16'($urandom)));
            else if (sel <= 6) prog.push_back(alu(4'($urandom_range(3)), 4'($urandom_range(3)), 4'($urandom_range(3))));
            else if (sel == 7) prog.push_back(NOP_W);
            else if (sel == 8) prog.push_back({bad_codes[$urandom_range(4)], 24'($urandom)});
            else               prog.push_back(alu(4'($urandom_range(3)), 4'($urandom_range(9)), 4'($urandom_range(9))));
         end
         prog.push_back(HALT_W);
         model_run(prog);
         load_prog(prog);
         do_reset();
         run_prog(t % 2 == 1);
         checks += 2;
         if (err !== m_err)       begin errors++; $display("FAIL rand%0d_err got %b exp %b", t, err, m_err); end
         if (pc !== 9'(m_pc))     begin errors++; $display("FAIL rand%0d_pc got %0d exp %0d", t, pc, m_pc); end
         for (int i = 0; i < 16; i++) begin
            dbg_sel = 4'(i); #1;
            checks++;
            if (dbg_data !== m_reg[i]) begin errors++; $display("FAIL rand%0d_r%0d got %h exp %h", t, i, dbg_data, m_reg[i]); end
         end
      end
   endtask

   task automatic test_pc_wrap();
      s_working = 1'b0;
      for (int i = 0; i < 16; i++) begin
         s_addr  = 4'(i);
         s_wdata = (i == 15) ? irmov(4'd1, 16'h1234) : NOP_W;
         s_wr    = 1'b1;
         tick();
      end
      s_wr    = 1'b0;
      s_reset = 1'b1;
      tick();
      s_reset   = 1'b0;
      s_working = 1'b1;
      for (int k = 1; k <= 20; k++) begin
         tick();
         checks++;
         if (s_pc !== 4'(k % 16)) begin errors++; $display("FAIL wrap_pc_edge%0d got %0d exp %0d", k, s_pc, k % 16); end
      end
      s_working = 1'b0;
      s_dbg_sel = 4'd1; #1;
      checks++;
      if (s_dbg_data !== 32'h1234) begin errors++; $display("FAIL wrap_r1 got %h exp 1234", s_dbg_data); end
      s_dbg_sel = 4'd9; #1;
      checks++;
      if (s_dbg_data !== 32'h0) begin errors++; $display("FAIL wrap_r9 got %h exp 0", s_dbg_data); end
      checks += 2;
      if (s_err !== 1'b0)    begin errors++; $display("FAIL wrap_err got %b exp 0", s_err); end
      if (s_halted !== 1'b0) begin errors++; $display("FAIL wrap_halted got %b exp 0", s_halted); end
   endtask

   initial begin
      reset = 1'b0; working = 1'b0; wr = 1'b0; addr = '0; wdata = '0; dbg_sel = '0;
      s_reset = 1'b0; s_working = 1'b0; s_wr = 1'b0; s_addr = '0; s_wdata = '0; s_dbg_sel = '0;

      for (int i = 0; i < 8; i++) prog1.push_back(irmov(4'(i), 16'(8'h80 + i)));
      prog1.push_back(alu(4'h0, 4'd0, 4'd1));
      prog1.push_back(alu(4'h1, 4'd2, 4'd3));
      prog1.push_back(alu(4'h2, 4'd4, 4'd5));
      prog1.push_back(alu(4'h3, 4'd6, 4'd7));
      prog1.push_back(HALT_W);
      exp1 = '{32'h101, 32'h81, 32'hFFFF_FFFF, 32'h83, 32'h84, 32'h85, 32'h01, 32'h87,
               32'h0, 32'h0, 32'h0, 32'h0, 32'h0, 32'h0, 32'h0, 32'h0};

      tick();
      test_reset();
      test_alu_ops();
      test_forwarding();
      test_pause();
      test_illegal();
      test_reset_midrun();
      test_random_programs();
      test_pc_wrap();

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
